// File: rtl/mod_delay_pkg.sv
// Shared encodings and the saturation helper for the modulated delay effect.
package mod_delay_pkg;

  typedef enum logic [1:0] {
    MODE_VIBRATO = 2'd0,
    MODE_CHORUS  = 2'd1,
    MODE_FLANGER = 2'd2,
    MODE_BYPASS  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_MIX   = 2'd2,
    ST_WRITE = 2'd3
  } state_e;

  localparam int DEF_DATA_WIDTH  = 16;
  localparam int DEF_ADDR_WIDTH  = 10;
  localparam int DEF_PHASE_WIDTH = 24;

  // Clamp a sign-extended value into the signed range of a width-bit sample.
  function automatic logic signed [31:0] sat(input logic signed [31:0] value, input int width);
    logic signed [31:0] hi_v;
    logic signed [31:0] lo_v;
    hi_v = (32'sd1 <<< (width - 1)) - 32'sd1;
    lo_v = -(32'sd1 <<< (width - 1));
    if (value > hi_v) begin
      return hi_v;
    end else if (value < lo_v) begin
      return lo_v;
    end else begin
      return value;
    end
  endfunction

endpackage

// File: rtl/mod_delay_fx_ram.sv
// Single-port stereo delay line with a registered read port; contents are
// intentionally not reset.
module delay_ram
  import mod_delay_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                      clk,
  input  logic                      i_we,
  input  logic [ADDR_WIDTH-1:0]     i_addr,
  input  logic [2*DATA_WIDTH-1:0]   i_wdata,
  output logic [2*DATA_WIDTH-1:0]   o_rdata
);

  logic [2*DATA_WIDTH-1:0] r_mem [0:(1<<ADDR_WIDTH)-1];
  logic [2*DATA_WIDTH-1:0] r_rdata;

  // Storage array with read-before-write behaviour on the shared address.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mod_delay_fx.sv
// LFO-modulated stereo delay: vibrato, chorus, flanger (with feedback) or bypass,
// processing one frame per four clocks through a single-port delay line.
module mod_delay_fx
  import mod_delay_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int PHASE_WIDTH = DEF_PHASE_WIDTH
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          sample_valid,
  input  logic signed [DATA_WIDTH-1:0]  audio_left_in,
  input  logic signed [DATA_WIDTH-1:0]  audio_right_in,
  input  logic [PHASE_WIDTH-1:0]        fcw,
  input  logic [ADDR_WIDTH-1:0]         depth,
  input  logic [1:0]                    mode,
  output logic signed [DATA_WIDTH-1:0]  audio_left_out,
  output logic signed [DATA_WIDTH-1:0]  audio_right_out,
  output logic                          out_valid,
  output logic                          overrun
);

  state_e                        r_state;
  mode_e                         r_mode;
  logic [ADDR_WIDTH-1:0]         r_depth;
  logic [ADDR_WIDTH-1:0]         r_wr_ptr;
  logic [ADDR_WIDTH-1:0]         r_fill;
  logic [PHASE_WIDTH-1:0]        r_phase;
  logic signed [DATA_WIDTH-1:0]  r_dry_l;
  logic signed [DATA_WIDTH-1:0]  r_dry_r;
  logic signed [DATA_WIDTH-1:0]  r_wet_l;
  logic signed [DATA_WIDTH-1:0]  r_wet_r;
  logic signed [DATA_WIDTH-1:0]  r_out_l;
  logic signed [DATA_WIDTH-1:0]  r_out_r;
  logic                          r_wet_ok;
  logic                          r_out_valid;
  logic                          r_overrun;

  logic [ADDR_WIDTH-1:0]         w_seg;
  logic [ADDR_WIDTH-1:0]         w_tri;
  logic [2*ADDR_WIDTH-1:0]       w_prod;
  logic [ADDR_WIDTH:0]           w_delay;
  logic [ADDR_WIDTH-1:0]         w_rd_addr;
  logic [ADDR_WIDTH-1:0]         w_ram_addr;
  logic                          w_ram_we;
  logic                          w_wet_ok;
  logic [2*DATA_WIDTH-1:0]       w_ram_rdata;
  logic [2*DATA_WIDTH-1:0]       w_ram_wdata;
  logic signed [DATA_WIDTH-1:0]  w_mix_wet_l;
  logic signed [DATA_WIDTH-1:0]  w_mix_wet_r;
  logic signed [DATA_WIDTH:0]    w_sum_l;
  logic signed [DATA_WIDTH:0]    w_sum_r;
  logic signed [DATA_WIDTH-1:0]  w_mix_l;
  logic signed [DATA_WIDTH-1:0]  w_mix_r;
  logic signed [DATA_WIDTH:0]    w_fb_l;
  logic signed [DATA_WIDTH:0]    w_fb_r;
  logic signed [DATA_WIDTH-1:0]  w_fb_sat_l;
  logic signed [DATA_WIDTH-1:0]  w_fb_sat_r;

  // Triangle LFO scales depth; the +1 keeps the tap strictly behind the write pointer.
  assign w_seg     = r_phase[PHASE_WIDTH-2 -: ADDR_WIDTH];
  assign w_tri     = r_phase[PHASE_WIDTH-1] ? ~w_seg : w_seg;
  assign w_prod    = {{ADDR_WIDTH{1'b0}}, w_tri} * {{ADDR_WIDTH{1'b0}}, r_depth};
  assign w_delay   = {1'b0, ADDR_WIDTH'(w_prod >> ADDR_WIDTH)} + {{ADDR_WIDTH{1'b0}}, 1'b1};
  assign w_rd_addr = r_wr_ptr - w_delay[ADDR_WIDTH-1:0];
  assign w_wet_ok  = ({1'b0, r_fill} >= w_delay);

  assign w_ram_we   = (r_state == ST_WRITE);
  assign w_ram_addr = w_ram_we ? r_wr_ptr : w_rd_addr;

  // Taps older than anything written since reset read as silence.
  assign w_mix_wet_l = r_wet_ok ? $signed(w_ram_rdata[2*DATA_WIDTH-1 -: DATA_WIDTH])
                                : {DATA_WIDTH{1'b0}};
  assign w_mix_wet_r = r_wet_ok ? $signed(w_ram_rdata[DATA_WIDTH-1:0])
                                : {DATA_WIDTH{1'b0}};

  assign w_sum_l = {w_mix_wet_l[DATA_WIDTH-1], w_mix_wet_l} + {r_dry_l[DATA_WIDTH-1], r_dry_l};
  assign w_sum_r = {w_mix_wet_r[DATA_WIDTH-1], w_mix_wet_r} + {r_dry_r[DATA_WIDTH-1], r_dry_r};

  // Output mix selection by the mode latched with the frame.
  always_comb begin
    w_mix_l = r_dry_l;
    w_mix_r = r_dry_r;
    case (r_mode)
      MODE_VIBRATO: begin
        w_mix_l = w_mix_wet_l;
        w_mix_r = w_mix_wet_r;
      end
      MODE_CHORUS, MODE_FLANGER: begin
        w_mix_l = w_sum_l[DATA_WIDTH:1];
        w_mix_r = w_sum_r[DATA_WIDTH:1];
      end
      MODE_BYPASS: begin
        w_mix_l = r_dry_l;
        w_mix_r = r_dry_r;
      end
      default: begin
        w_mix_l = r_dry_l;
        w_mix_r = r_dry_r;
      end
    endcase
  end

  // Flanger feedback: half the tap is fed back into the line, clamped to full scale.
  assign w_fb_l = {r_dry_l[DATA_WIDTH-1], r_dry_l}
                + {r_wet_l[DATA_WIDTH-1], r_wet_l[DATA_WIDTH-1], r_wet_l[DATA_WIDTH-1:1]};
  assign w_fb_r = {r_dry_r[DATA_WIDTH-1], r_dry_r}
                + {r_wet_r[DATA_WIDTH-1], r_wet_r[DATA_WIDTH-1], r_wet_r[DATA_WIDTH-1:1]};
  assign w_fb_sat_l = DATA_WIDTH'(sat(32'(w_fb_l), DATA_WIDTH));
  assign w_fb_sat_r = DATA_WIDTH'(sat(32'(w_fb_r), DATA_WIDTH));

  assign w_ram_wdata = (r_mode == MODE_FLANGER) ? {w_fb_sat_l, w_fb_sat_r}
                                                : {r_dry_l, r_dry_r};

  delay_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_addr  (w_ram_addr),
    .i_wdata (w_ram_wdata),
    .o_rdata (w_ram_rdata)
  );

  // Frame sequencer: accept, read the tap, mix, then commit the write and advance.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_mode      <= MODE_VIBRATO;
      r_depth     <= {ADDR_WIDTH{1'b0}};
      r_wr_ptr    <= {ADDR_WIDTH{1'b0}};
      r_fill      <= {ADDR_WIDTH{1'b0}};
      r_phase     <= {PHASE_WIDTH{1'b0}};
      r_dry_l     <= {DATA_WIDTH{1'b0}};
      r_dry_r     <= {DATA_WIDTH{1'b0}};
      r_wet_l     <= {DATA_WIDTH{1'b0}};
      r_wet_r     <= {DATA_WIDTH{1'b0}};
      r_out_l     <= {DATA_WIDTH{1'b0}};
      r_out_r     <= {DATA_WIDTH{1'b0}};
      r_wet_ok    <= 1'b0;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      if (sample_valid && (r_state != ST_IDLE)) begin
        r_overrun <= 1'b1;
      end else begin
        r_overrun <= r_overrun;
      end
      case (r_state)
        ST_IDLE: begin
          if (sample_valid) begin
            r_dry_l <= audio_left_in;
            r_dry_r <= audio_right_in;
            r_mode  <= mode_e'(mode);
            r_depth <= depth;
            r_state <= ST_READ;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_READ: begin
          r_wet_ok <= w_wet_ok;
          r_state  <= ST_MIX;
        end
        ST_MIX: begin
          r_wet_l     <= w_mix_wet_l;
          r_wet_r     <= w_mix_wet_r;
          r_out_l     <= w_mix_l;
          r_out_r     <= w_mix_r;
          r_out_valid <= 1'b1;
          r_state     <= ST_WRITE;
        end
        ST_WRITE: begin
          r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
          r_phase  <= r_phase + fcw;
          if (r_fill != {ADDR_WIDTH{1'b1}}) begin
            r_fill <= r_fill + ADDR_WIDTH'(1);
          end else begin
            r_fill <= r_fill;
          end
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign audio_left_out  = r_out_l;
  assign audio_right_out = r_out_r;
  assign out_valid       = r_out_valid;
  assign overrun         = r_overrun;

endmodule

// File: tb/tb_mod_delay_fx.sv
// Self-checking bench for mod_delay_fx: directed vector table, overrun and
// mid-frame reset sequences, then random frames against an arithmetic model.
module tb_mod_delay_fx;

  localparam int DW  = 16;
  localparam int AW  = 10;
  localparam int PW  = 24;
  localparam int NFR = 1 << AW;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic                  sample_valid;
  logic signed [DW-1:0]  l_in;
  logic signed [DW-1:0]  r_in;
  logic [PW-1:0]         fcw;
  logic [AW-1:0]         depth;
  logic [1:0]            mode;
  logic signed [DW-1:0]  l_out;
  logic signed [DW-1:0]  r_out;
  logic                  out_valid;
  logic                  overrun;

  mod_delay_fx #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PHASE_WIDTH(PW)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .sample_valid    (sample_valid),
    .audio_left_in   (l_in),
    .audio_right_in  (r_in),
    .fcw             (fcw),
    .depth           (depth),
    .mode            (mode),
    .audio_left_out  (l_out),
    .audio_right_out (r_out),
    .out_valid       (out_valid),
    .overrun         (overrun)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    bit            rst;
    logic [1:0]    md;
    logic [AW-1:0] dp;
    int            li;
    int            ri;
    int            el;
    int            er;
  } vec_t;

  vec_t tbl [11];

  int     mem_l [NFR];
  int     mem_r [NFR];
  int     m_wr;
  int     m_fill;
  longint m_ph;

  logic signed [DW-1:0] ol;
  logic signed [DW-1:0] orr;

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int clamp16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Reference: delay from the triangle LFO, fill-gated tap, mix and line update.
  task automatic model_frame(input int dl, input int dr, input int md, input int dp,
                             input longint f, output int xl, output int xr);
    longint seg, tv, dly;
    int rd, wl, wr, nl, nr;
    seg = (m_ph / (longint'(1) << (PW - 1 - AW))) % NFR;
    tv  = (m_ph >= (longint'(1) << (PW - 1))) ? (NFR - 1 - seg) : seg;
    dly = 1 + (tv * dp) / NFR;
    rd  = int'((m_wr - dly + NFR) % NFR);
    wl  = (m_fill >= dly) ? mem_l[rd] : 0;
    wr  = (m_fill >= dly) ? mem_r[rd] : 0;
    case (md)
      0: begin xl = wl; xr = wr; end
      3: begin xl = dl; xr = dr; end
      default: begin xl = (dl + wl) >>> 1; xr = (dr + wr) >>> 1; end
    endcase
    nl = (md == 2) ? clamp16(dl + (wl >>> 1)) : dl;
    nr = (md == 2) ? clamp16(dr + (wr >>> 1)) : dr;
    mem_l[m_wr] = nl;
    mem_r[m_wr] = nr;
    m_wr   = (m_wr + 1) % NFR;
    m_ph   = (m_ph + f) % (longint'(1) << PW);
    m_fill = (m_fill < NFR - 1) ? m_fill + 1 : NFR - 1;
  endtask

  task automatic do_reset();
    reset_n      = 1'b0;
    sample_valid = 1'b0;
    @(negedge clk);
    check("reset out_valid", out_valid, 0);
    check("reset overrun", overrun, 0);
    check("reset left", l_out, 0);
    check("reset right", r_out, 0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // One frame at the minimum spacing; latched controls are scrambled after acceptance.
  task automatic run_frame(input string tag, input int li, input int ri, input logic [1:0] m,
                           input logic [AW-1:0] d, input logic [PW-1:0] f,
                           output logic signed [DW-1:0] xo_l, output logic signed [DW-1:0] xo_r);
    mode = m; depth = d; fcw = f;
    l_in = DW'(li); r_in = DW'(ri);
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    mode  = ~m;
    depth = ~d;
    check({tag, " valid edge1"}, out_valid, 0);
    @(negedge clk);
    check({tag, " valid edge2"}, out_valid, 0);
    @(negedge clk);
    check({tag, " valid edge3"}, out_valid, 1);
    xo_l = l_out;
    xo_r = r_out;
    @(negedge clk);
    check({tag, " valid edge4"}, out_valid, 0);
  endtask

  initial begin
    int dl, dr, xl, xr, md, dp, last_acc, exp_edge, exp_l, exp_r;
    bit ovr_exp, sv;
    longint f;

    reset_n = 1'b0; sample_valid = 1'b0;
    l_in = '0; r_in = '0; fcw = '0; depth = '0; mode = 2'd0;
    @(negedge clk);

    tbl[0]  = '{1'b1, 2'd3, 10'd0, 1000, -1000, 1000, -1000};
    tbl[1]  = '{1'b1, 2'd0, 10'd0, 16384, -16384, 0, 0};
    tbl[2]  = '{1'b0, 2'd0, 10'd0, 0, 0, 16384, -16384};
    tbl[3]  = '{1'b0, 2'd0, 10'd0, 0, 0, 0, 0};
    tbl[4]  = '{1'b1, 2'd1, 10'd4, 32767, 32767, 16383, 16383};
    tbl[5]  = '{1'b0, 2'd1, 10'd4, 32767, 32767, 32767, 32767};
    tbl[6]  = '{1'b0, 2'd1, 10'd4, -32768, -32768, -1, -1};
    tbl[7]  = '{1'b1, 2'd2, 10'd0, 30000, -30000, 15000, -15000};
    tbl[8]  = '{1'b0, 2'd2, 10'd0, 30000, -30000, 30000, -30000};
    tbl[9]  = '{1'b0, 2'd2, 10'd0, 30000, -30000, 31383, -31384};
    tbl[10] = '{1'b0, 2'd0, 10'd0, 0, 0, 32767, -32768};

    for (int i = 0; i < 11; i++) begin
      if (tbl[i].rst) do_reset();
      run_frame($sformatf("vec%0d", i), tbl[i].li, tbl[i].ri, tbl[i].md, tbl[i].dp,
                24'd0, ol, orr);
      check($sformatf("vec%0d left", i), ol, tbl[i].el);
      check($sformatf("vec%0d right", i), orr, tbl[i].er);
    end

    // Strobes every second cycle: frames on edges 0 and 4 survive, 2 and 6 drop.
    do_reset();
    mode = 2'd3; depth = 10'd0; fcw = 24'd0;
    for (int k = 0; k < 12; k++) begin
      sample_valid = (k < 8) && (k % 2 == 0);
      l_in = DW'(100 * (k + 1));
      r_in = DW'(-100 * (k + 1));
      @(negedge clk);
      check($sformatf("ovr out_valid e%0d", k), out_valid, (k == 2 || k == 6) ? 1 : 0);
      if (k == 2 || k == 6) begin
        check($sformatf("ovr left e%0d", k), l_out, 100 * (k - 1));
        check($sformatf("ovr right e%0d", k), r_out, -100 * (k - 1));
      end
      check($sformatf("ovr flag e%0d", k), overrun, (k >= 2) ? 1 : 0);
    end
    repeat (5) @(negedge clk);
    check("ovr sticky", overrun, 1);
    reset_n = 1'b0;
    #1;
    check("ovr cleared by reset", overrun, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Reset while the frame sits in MIX.
    do_reset();
    run_frame("pre", 500, -500, 2'd3, 10'd0, 24'd0, ol, orr);
    check("pre left", ol, 500);
    mode = 2'd3; l_in = 16'sd777; r_in = 16'sd777;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midrst out_valid", out_valid, 0);
    check("midrst left", l_out, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("midrst hold %0d", k), out_valid, 0);
    end
    reset_n = 1'b1;
    run_frame("post0", 1234, 1234, 2'd0, 10'd0, 24'd0, ol, orr);
    check("post0 left", ol, 0);
    check("post0 right", orr, 0);
    run_frame("post1", 0, 0, 2'd0, 10'd0, 24'd0, ol, orr);
    check("post1 left", ol, 1234);

    // Random frames and strobes against the model.
    do_reset();
    fcw = 24'd0;
    m_wr = 0; m_fill = 0; m_ph = 0;
    last_acc = -100; exp_edge = -1; ovr_exp = 1'b0; exp_l = 0; exp_r = 0;
    for (int e = 0; e < 8000; e++) begin
      sv = ($urandom_range(0, 2) == 0);
      dl = int'($urandom_range(0, 65535)) - 32768;
      dr = int'($urandom_range(0, 65535)) - 32768;
      md = int'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: dp = 0;
        1: dp = int'($urandom_range(1, 8));
        default: dp = int'($urandom_range(0, NFR - 1));
      endcase
      sample_valid = sv;
      l_in  = DW'(dl);
      r_in  = DW'(dr);
      mode  = 2'(md);
      depth = AW'(dp);
      if (sv) begin
        if (e >= last_acc + 4) begin
          case ($urandom_range(0, 2))
            0: f = 0;
            1: f = longint'($urandom_range(1, 5000));
            default: f = longint'($urandom_range(0, (1 << PW) - 1));
          endcase
          fcw = PW'(f);
          model_frame(dl, dr, md, dp, f, xl, xr);
          exp_l = xl; exp_r = xr;
          last_acc = e;
          exp_edge = e + 2;
        end else begin
          ovr_exp = 1'b1;
        end
      end
      @(negedge clk);
      check("rnd out_valid", out_valid, (e == exp_edge) ? 1 : 0);
      if (e == exp_edge) begin
        check("rnd left", l_out, exp_l);
        check("rnd right", r_out, exp_r);
      end
      check("rnd overrun", overrun, ovr_exp);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mod_delay_fx.md
MOD_DELAY_FX -- requirements
Module: mod_delay_fx

Interface
REQ-001 Parameter DATA_WIDTH, default 16, SHALL set the signed sample width per channel.
REQ-002 Parameter ADDR_WIDTH, default 10, SHALL set the delay-line depth to 2^ADDR_WIDTH stereo frames.
REQ-003 Parameter PHASE_WIDTH, default 24, SHALL set the LFO phase-accumulator width.
REQ-004 clk  in  1  sole clock; every register updates on its rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 sample_valid  in  1  one-cycle strobe; audio_*_in are valid in that cycle.
REQ-007 audio_left_in, audio_right_in  in  DATA_WIDTH signed  input frame.
REQ-008 fcw  in  PHASE_WIDTH  LFO phase increment per accepted frame.
REQ-009 depth  in  ADDR_WIDTH  maximum modulated delay, in frames.
REQ-010 mode  in  2  0 vibrato, 1 chorus, 2 flanger, 3 bypass.
REQ-011 audio_left_out, audio_right_out  out  DATA_WIDTH signed  registered output frame.
REQ-012 out_valid  out  1  one-cycle strobe; outputs are updated in that cycle.
REQ-013 overrun  out  1  sticky flag: a frame was dropped.

Function
REQ-014 FSM states SHALL be IDLE, READ, MIX, WRITE, with the fixed sequence IDLE->READ->MIX->WRITE->IDLE; only IDLE accepts sample_valid.
REQ-015 In IDLE, sample_valid SHALL latch both inputs, mode and depth, then move to READ.
REQ-016 In READ, the delay-line read address SHALL be (wr_ptr - delay) mod 2^ADDR_WIDTH, with delay = 1 + ((tri * depth) >> ADDR_WIDTH).
REQ-017 tri SHALL be the ADDR_WIDTH-bit triangle formed from the phase MSBs: bits [PHASE_WIDTH-2 -: ADDR_WIDTH], inverted when the MSB is 1.
REQ-018 delay SHALL lie in 1..max(depth,1); when depth=0, delay SHALL equal 1.
REQ-019 wet SHALL be the read frame when fill >= delay, and 0 otherwise; fill counts frames written since reset and saturates at 2^ADDR_WIDTH-1.
REQ-020 In MIX, outputs SHALL be set by mode: 0 -> wet; 1 and 2 -> (dry + wet) >>> 1, computed at DATA_WIDTH+1 bits; 3 -> dry.
REQ-021 out_valid SHALL pulse for exactly the cycle following the MIX edge, which is 3 rising edges after the sample_valid edge.
REQ-022 In WRITE, the frame written at wr_ptr SHALL be dry, except in mode 2, where it SHALL be sat(dry + (wet >>> 1)).
REQ-023 sat() SHALL clamp to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
REQ-024 At the WRITE edge, wr_ptr SHALL increment modulo 2^ADDR_WIDTH, phase SHALL add fcw modulo 2^PHASE_WIDTH, and fill SHALL increment.
REQ-025 sample_valid in any state other than IDLE SHALL drop the frame and set overrun; the in-flight frame SHALL complete normally.
REQ-026 The minimum accepted frame spacing SHALL be 4 cycles; sample_valid coincident with the WRITE->IDLE transition SHALL be dropped.
REQ-027 Because delay >= 1, the read address SHALL never equal the write address of the same frame.

Reset
REQ-028 While reset_n is low: state=IDLE, wr_ptr=0, phase=0, fill=0, outputs=0, out_valid=0, overrun=0.
REQ-029 Delay-line RAM contents SHALL NOT be reset; fill gating (REQ-019) SHALL mask stale data.
REQ-030 Reset asserted mid-frame SHALL abort the frame with no RAM write and no out_valid.

Structure
REQ-031 Package mod_delay_pkg SHALL hold the mode encodings, the FSM state enum and the sat function.
REQ-032 A sub-module delay_ram SHALL be used: single-port, synchronous read, 2*DATA_WIDTH x 2^ADDR_WIDTH, storing {left,right}.

Verification
REQ-033 Mode 3, in (1000,-1000) -> out (1000,-1000), with out_valid exactly 3 edges after sample_valid.
REQ-034 Mode 0, depth=0, fcw=0, impulse 16384 then zeros -> impulse appears on the next frame; out=0 before it.
REQ-035 Mode 1, fcw=0, depth=4 (delay=1), constant 32767 -> first out 16383, then 32767 (no overflow).
REQ-036 Mode 2, depth=0, constant 30000 -> written value saturates to 32767; outputs stay in range.
REQ-037 sample_valid at spacing 2 -> every second frame dropped, overrun=1 and held until reset_n low.
REQ-038 reset_n low during MIX -> no out_valid; first frame after release sees wet=0.
